regfile_en: RTL and testbench

- Parametrised successor to the single-bit enabled flip-flop.
- Provides a DEPTH x WIDTH register file with:
  - one write port carrying a write enable and a per-lane write mask,
  - two independent registered read ports,
  - a per-word valid bit with bulk clear.
- Used as the team's general storage element wherever several enabled registers were previously hand-instantiated.

---
 rtl/regfile_en.sv | 118 +++++++++++
 tb/tb_regfile_en.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_en.sv
// DEPTH x WIDTH register file: one lane-masked write port, two registered read
// ports, and a per-word valid bit with bulk clear.
module regfile_en #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int LANE_W = 8,
    parameter int AW     = 3,
    parameter int BYPASS = 1,
    localparam int LANES = WIDTH / LANE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [LANES-1:0] wr_mask,
    input  logic             clr,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_valid_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid_b
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] lane_bits;
    logic [WIDTH-1:0] wr_word;
    logic             wr_ok;

    always_comb begin
        lane_bits = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_bits[i*LANE_W +: LANE_W] = {LANE_W{wr_mask[i]}};
        end
    end

    // Addresses at or above DEPTH are dropped, never aliased onto a real word.
    assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_W);
    assign wr_word = (mem[wr_addr] & ~lane_bits) | (wr_data & lane_bits);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // Later assignment wins: a write in the clear cycle leaves its word valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (clr) begin
                valid <= '0;
            end
            if (wr_ok) begin
                valid[wr_addr] <= 1'b1;
            end
        end
    end

    logic [1:0]       rd_en_p;
    logic [AW-1:0]    rd_addr_p  [2];
    logic [WIDTH-1:0] rd_data_q  [2];
    logic [1:0]       rd_valid_q;

    assign rd_en_p      = {rd_en_b, rd_en_a};
    assign rd_addr_p[0] = rd_addr_a;
    assign rd_addr_p[1] = rd_addr_b;
    assign rd_data_a    = rd_data_q[0];
    assign rd_data_b    = rd_data_q[1];
    assign rd_valid_a   = rd_valid_q[0];
    assign rd_valid_b   = rd_valid_q[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic             in_range;
        logic             hit;
        logic [WIDTH-1:0] next_data;
        logic             next_valid;

        // With BYPASS the port sees the post-edge state; otherwise the pre-edge state.
        always_comb begin
            in_range   = {1'b0, rd_addr_p[p]} < DEPTH_W;
            hit        = wr_ok && (wr_addr == rd_addr_p[p]);
            next_data  = '0;
            next_valid = 1'b0;
            if (in_range) begin
                if ((BYPASS != 0) && hit) begin
                    next_data  = wr_word;
                    next_valid = 1'b1;
                end else begin
                    next_data  = mem[rd_addr_p[p]];
                    next_valid = valid[rd_addr_p[p]] && !((BYPASS != 0) && clr);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q[p]  <= '0;
                rd_valid_q[p] <= 1'b0;
            end else if (rd_en_p[p]) begin
                rd_data_q[p]  <= next_data;
                rd_valid_q[p] <= next_valid;
            end
        end
    end

endmodule

// File: tb/tb_regfile_en.sv
// Bench for regfile_en: three instances (default, BYPASS=0, DEPTH=6) share one
// directed stimulus and are checked every cycle against an array model.
module tb_regfile_en;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_mask;
    logic        clr;
    logic        rd_en_a;
    logic [2:0]  rd_addr_a;
    logic        rd_en_b;
    logic [2:0]  rd_addr_b;

    logic [15:0] da [3];
    logic [15:0] db [3];
    logic        va [3];
    logic        vb [3];

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    logic [15:0] m_mem [3][8];
    logic        m_val [3][8];
    logic [15:0] e_da  [3];
    logic [15:0] e_db  [3];
    logic        e_va  [3];
    logic        e_vb  [3];

    regfile_en #(.WIDTH(16), .DEPTH(8), .LANE_W(8), .AW(3), .BYPASS(1)) u_def (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .clr(clr),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(da[0]), .rd_valid_a(va[0]),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(db[0]), .rd_valid_b(vb[0])
    );

    regfile_en #(.WIDTH(16), .DEPTH(8), .LANE_W(8), .AW(3), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .clr(clr),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(da[1]), .rd_valid_a(va[1]),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(db[1]), .rd_valid_b(vb[1])
    );

    regfile_en #(.WIDTH(16), .DEPTH(6), .LANE_W(8), .AW(3), .BYPASS(1)) u_d6 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .clr(clr),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(da[2]), .rd_valid_a(va[2]),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(db[2]), .rd_valid_b(vb[2])
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int k, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] pick(input int dep, input logic [2:0] addr,
                                         input logic [15:0] word, input logic v);
        if (int'(addr) >= dep) return 17'd0;
        return {v, word};
    endfunction

    // Model: apply clear then write to the word array; a bypassing port reads
    // the updated array, a non-bypassing port reads the snapshot taken before.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int          dep;
            bit          byp;
            logic [15:0] old_mem [8];
            logic        old_val [8];
            logic [16:0] r;
            dep = (k == 2) ? 6 : 8;
            byp = (k != 1);
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    m_mem[k][i] = 16'h0;
                    m_val[k][i] = 1'b0;
                end
                e_da[k] = 16'h0; e_va[k] = 1'b0;
                e_db[k] = 16'h0; e_vb[k] = 1'b0;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    old_mem[i] = m_mem[k][i];
                    old_val[i] = m_val[k][i];
                end
                if (clr) begin
                    for (int i = 0; i < 8; i++) m_val[k][i] = 1'b0;
                end
                if (wr_en && int'(wr_addr) < dep) begin
                    if (wr_mask[0]) m_mem[k][wr_addr][7:0]  = wr_data[7:0];
                    if (wr_mask[1]) m_mem[k][wr_addr][15:8] = wr_data[15:8];
                    m_val[k][wr_addr] = 1'b1;
                end
                if (rd_en_a) begin
                    r = byp ? pick(dep, rd_addr_a, m_mem[k][rd_addr_a], m_val[k][rd_addr_a])
                            : pick(dep, rd_addr_a, old_mem[rd_addr_a], old_val[rd_addr_a]);
                    {e_va[k], e_da[k]} = r;
                end
                if (rd_en_b) begin
                    r = byp ? pick(dep, rd_addr_b, m_mem[k][rd_addr_b], m_val[k][rd_addr_b])
                            : pick(dep, rd_addr_b, old_mem[rd_addr_b], old_val[rd_addr_b]);
                    {e_vb[k], e_db[k]} = r;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                check("model_rd_data_a", k, da[k], e_da[k]);
                check("model_rd_valid_a", k, {15'd0, va[k]}, {15'd0, e_va[k]});
                check("model_rd_data_b", k, db[k], e_db[k]);
                check("model_rd_valid_b", k, {15'd0, vb[k]}, {15'd0, e_vb[k]});
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 0; clr = 0; rd_en_a = 0; rd_en_b = 0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] m);
        wr_en = 1; wr_addr = a; wr_data = d; wr_mask = m;
        cycle();
        idle();
    endtask

    task automatic do_read(input logic [2:0] a, input logic [2:0] b);
        rd_en_a = 1; rd_addr_a = a; rd_en_b = 1; rd_addr_b = b;
        cycle();
        idle();
    endtask

    initial begin
        rst = 1; wr_addr = 0; wr_data = 0; wr_mask = 0; rd_addr_a = 0; rd_addr_b = 0;
        idle();
        cycle();
        chk_on = 1;
        cycle();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            check("reset_rd_data_a", k, da[k], 16'h0000);
            check("reset_rd_valid_b", k, {15'd0, vb[k]}, 16'h0000);
        end

        // Full write then read, plus an unwritten word.
        do_write(3'd3, 16'hBEEF, 2'b11);
        do_read(3'd3, 3'd4);
        check("t1_rd_data_a", 0, da[0], 16'hBEEF);
        check("t1_rd_valid_a", 0, {15'd0, va[0]}, 16'h0001);
        check("t1_rd_data_b", 0, db[0], 16'h0000);
        check("t1_rd_valid_b", 0, {15'd0, vb[0]}, 16'h0000);

        // Lane-masked write and an all-zero mask.
        do_write(3'd3, 16'h1234, 2'b01);
        do_read(3'd3, 3'd3);
        check("t2_partial", 0, da[0], 16'hBE34);
        do_write(3'd5, 16'hFFFF, 2'b00);
        do_read(3'd5, 3'd5);
        check("t2_mask0_data", 0, da[0], 16'h0000);
        check("t2_mask0_valid", 0, {15'd0, va[0]}, 16'h0001);

        // Read-during-write on the same edge.
        do_write(3'd2, 16'hAAAA, 2'b11);
        wr_en = 1; wr_addr = 3'd2; wr_data = 16'h5555; wr_mask = 2'b10;
        rd_en_a = 1; rd_addr_a = 3'd2;
        cycle();
        idle();
        check("t3_bypass", 0, da[0], 16'h55AA);
        check("t3_nobypass", 1, da[1], 16'hAAAA);
        check("t3_nobypass_valid", 1, {15'd0, va[1]}, 16'h0001);

        // Clear with a simultaneous write and a read of another word.
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'h1000 + 16'(i), 2'b11);
        clr = 1; wr_en = 1; wr_addr = 3'd6; wr_data = 16'h0F0F; wr_mask = 2'b11;
        rd_en_b = 1; rd_addr_b = 3'd0;
        cycle();
        idle();
        check("t4_clr_rd_bypass_valid", 0, {15'd0, vb[0]}, 16'h0000);
        check("t4_clr_rd_nobypass_valid", 1, {15'd0, vb[1]}, 16'h0001);
        check("t4_clr_rd_data", 0, db[0], 16'h1000);
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i), 3'(7 - i));
            if (i == 1) begin
                check("t4_data_kept", 0, da[0], 16'h1001);
                check("t4_cleared", 0, {15'd0, va[0]}, 16'h0000);
            end
            if (i == 6) check("t4_write_wins", 0, {15'd0, va[0]}, 16'h0001);
        end

        // Out-of-range address on the DEPTH=6 instance, then port A held.
        do_write(3'd7, 16'h7777, 2'b11);
        do_read(3'd7, 3'd6);
        check("t5_oor_data", 2, da[2], 16'h0000);
        check("t5_oor_valid", 2, {15'd0, va[2]}, 16'h0000);
        check("t5_inrange_data", 0, da[0], 16'h7777);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_addr = 3'd7; wr_data = 16'h1111 + 16'(i); wr_mask = 2'b11;
            rd_en_b = 1; rd_addr_b = 3'd7;
            cycle();
            idle();
        end
        check("t5_hold_a", 0, da[0], 16'h7777);
        check("t5_hold_valid", 0, {15'd0, va[0]}, 16'h0001);

        // Reset overrides write, clear and read in the same cycle.
        rst = 1; wr_en = 1; wr_addr = 3'd1; wr_data = 16'hABCD; wr_mask = 2'b11;
        clr = 1; rd_en_a = 1; rd_addr_a = 3'd1; rd_en_b = 1; rd_addr_b = 3'd1;
        cycle();
        rst = 0;
        idle();
        for (int k = 0; k < 3; k++) begin
            check("t6_rst_data_a", k, da[k], 16'h0000);
            check("t6_rst_valid_a", k, {15'd0, va[k]}, 16'h0000);
        end
        do_read(3'd1, 3'd3);
        check("t6_after_data", 0, da[0], 16'h0000);
        check("t6_after_valid", 0, {15'd0, va[0]}, 16'h0000);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
